bg_noise_estimator: RTL and testbench

Computes the per-lane background-noise estimate that the detection datapath subtracts from each period vector. It accumulates 2^LOG2_PERIODS valid period vectors of 16 signed 8-bit samples, each vector taken during a noise-only window. It then publishes the arithmetic mean of each lane as a 16-bit signed value on a 256-bit bus. It sits in front of the noise-removal stage and is its producer: its bg_noise lanes line up with the period-data lanes.

---
 rtl/bg_noise_estimator_pkg.sv | 24 ++
 rtl/bg_noise_lane_acc.sv | 39 +++
 rtl/bg_noise_estimator.sv | 115 +++++++++++
 tb/tb_bg_noise_estimator.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_noise_estimator_pkg.sv
// Shared types and widths for the background-noise estimator and its per-lane accumulators.
package bg_noise_estimator_pkg;

    localparam int unsigned LANES    = 16;
    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned NOISE_W  = 16;
    localparam int unsigned ACC_W    = 16;
    localparam int unsigned DATA_W   = LANES * SAMPLE_W;
    localparam int unsigned BUS_W    = LANES * NOISE_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } bgn_state_e;

    // Lane i of each vector occupies the i-th slice from the LSB end.
    typedef logic [LANES-1:0][SAMPLE_W-1:0] period_vec_t;
    typedef logic [LANES-1:0][NOISE_W-1:0]  noise_vec_t;

    function automatic logic [ACC_W-1:0] sext_sample(input logic [SAMPLE_W-1:0] s);
        return {{(ACC_W - SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

endpackage

// File: rtl/bg_noise_lane_acc.sv
// One lane's signed period accumulator; mean_c is the floor mean including the sample on the input.
module bg_noise_lane_acc
    import bg_noise_estimator_pkg::*;
#(
    parameter int unsigned LOG2_PERIODS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                add,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [NOISE_W-1:0]  mean_c
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] sum_c;

    // 16-bit sum is exact for up to 256 beats of 8-bit samples, so no saturation.
    always_comb begin
        sum_c  = acc_q + $signed(sext_sample(sample));
        acc_d  = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add) begin
            acc_d = sum_c;
        end
        mean_c = NOISE_W'(sum_c >>> LOG2_PERIODS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/bg_noise_estimator.sv
// Averages 2^LOG2_PERIODS noise-only period vectors per lane and publishes the means as bg_noise.
module bg_noise_estimator
    import bg_noise_estimator_pkg::*;
#(
    parameter int unsigned LOG2_PERIODS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              period_valid,
    input  logic [DATA_W-1:0] period_data,
    output logic              busy,
    output logic [BUS_W-1:0]  bg_noise,
    output logic              noise_update,
    output logic              noise_valid
);

    localparam int unsigned CNT_W     = LOG2_PERIODS + 1;
    localparam int unsigned LAST_BEAT = (1 << LOG2_PERIODS) - 1;

    bgn_state_e       state_q;
    bgn_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_q;
    logic             busy_d;
    logic             update_q;
    logic             update_d;
    logic             valid_q;
    logic             valid_d;
    noise_vec_t       bg_q;
    noise_vec_t       bg_d;

    logic             clr_c;
    logic             add_c;
    period_vec_t      samples_c;
    noise_vec_t       mean_c;

    assign samples_c = period_data;

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        bg_noise_lane_acc #(
            .LOG2_PERIODS (LOG2_PERIODS)
        ) u_acc (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr_c),
            .add    (add_c),
            .sample (samples_c[i]),
            .mean_c (mean_c[i])
        );
    end

    // Next-state, beat counting and publish of the final means.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bg_d     = bg_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        clr_c    = 1'b0;
        add_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr_c   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (period_valid) begin
                    add_c = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LAST_BEAT)) begin
                        bg_d     = mean_c;
                        update_d = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ACCUM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            update_q <= 1'b0;
            valid_q  <= 1'b0;
            bg_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            update_q <= update_d;
            valid_q  <= valid_d;
            bg_q     <= bg_d;
        end
    end

    assign busy         = busy_q;
    assign noise_update = update_q;
    assign noise_valid  = valid_q;
    assign bg_noise     = bg_q;

endmodule

// File: tb/tb_bg_noise_estimator.sv
// Directed bench for bg_noise_estimator at LOG2_PERIODS = 2, 8 and 0 with a queued mean scoreboard.
module tb_bg_noise_estimator;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         period_valid;
    logic [127:0] period_data;
    int           sel;

    logic         start_a, start_b, start_c;
    logic         busy_a, busy_b, busy_c;
    logic         upd_a, upd_b, upd_c;
    logic         val_a, val_b, val_c;
    logic [255:0] bg_a, bg_b, bg_c;

    logic         o_busy, o_upd, o_val;
    logic [255:0] o_bg;

    int           passed = 0;
    int           total  = 0;

    logic [127:0] beats[$];
    bit           gaps[$];
    bit           extra_start[$];
    logic [255:0] exp_q[$];

    always #5 clk = ~clk;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    bg_noise_estimator #(.LOG2_PERIODS(2)) u_dut_l2 (
        .clk (clk), .rst (rst), .start (start_a), .period_valid (period_valid),
        .period_data (period_data), .busy (busy_a), .bg_noise (bg_a),
        .noise_update (upd_a), .noise_valid (val_a)
    );

    bg_noise_estimator #(.LOG2_PERIODS(8)) u_dut_l8 (
        .clk (clk), .rst (rst), .start (start_b), .period_valid (period_valid),
        .period_data (period_data), .busy (busy_b), .bg_noise (bg_b),
        .noise_update (upd_b), .noise_valid (val_b)
    );

    bg_noise_estimator #(.LOG2_PERIODS(0)) u_dut_l0 (
        .clk (clk), .rst (rst), .start (start_c), .period_valid (period_valid),
        .period_data (period_data), .busy (busy_c), .bg_noise (bg_c),
        .noise_update (upd_c), .noise_valid (val_c)
    );

    always_comb begin
        o_busy = busy_a;
        o_upd  = upd_a;
        o_val  = val_a;
        o_bg   = bg_a;
        if (sel == 1) begin
            o_busy = busy_b;
            o_upd  = upd_b;
            o_val  = val_b;
            o_bg   = bg_b;
        end else if (sel == 2) begin
            o_busy = busy_c;
            o_upd  = upd_c;
            o_val  = val_c;
            o_bg   = bg_c;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] lane_vec(input int lane, input int val);
        logic [127:0] r = '0;
        r[8*lane +: 8] = 8'(val);
        return r;
    endfunction

    function automatic logic [127:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Floor mean of the queued beats, computed lane by lane in plain integers.
    function automatic logic [255:0] model(input int l);
        logic [255:0] r = '0;
        logic [7:0]   b8;
        int           s;
        for (int ln = 0; ln < 16; ln++) begin
            s = 0;
            foreach (beats[b]) begin
                b8 = beats[b][8*ln +: 8];
                s += int'($signed(b8));
            end
            r[16*ln +: 16] = 16'(s >>> l);
        end
        return r;
    endfunction

    // Start an estimate on the selected DUT, feed the queued beats, check the published result.
    task automatic estimate(input string tag, input int l, input logic sv,
                            input logic [127:0] sd, input int exp_lat);
        logic [255:0] held;
        int           cyc;
        int           bi;
        bit           done;
        bit           held_ok;
        bit           v;
        held    = o_bg;
        held_ok = 1'b1;
        done    = 1'b0;
        bi      = 0;
        exp_q.push_back(model(l));
        start        = 1'b1;
        period_valid = sv;
        period_data  = sd;
        step();
        start = 1'b0;
        cyc   = 1;
        chk({tag, "_busy_rise"}, 256'(o_busy), 256'(1));
        while (!done && cyc < 1000) begin
            v = (gaps.size() > 0) ? gaps.pop_front() : 1'b1;
            if (v && bi < beats.size()) begin
                period_data  = beats[bi];
                period_valid = 1'b1;
                bi++;
            end else begin
                period_data  = rand_vec();
                period_valid = 1'b0;
            end
            start = (extra_start.size() > 0) ? extra_start.pop_front() : 1'b0;
            step();
            start = 1'b0;
            cyc++;
            if (o_upd) begin
                done = 1'b1;
            end else if (o_bg !== held || o_busy !== 1'b1) begin
                held_ok = 1'b0;
            end
        end
        period_valid = 1'b0;
        chk({tag, "_held"}, 256'(held_ok), 256'(1));
        chk({tag, "_latency"}, 256'(done ? cyc : -1), 256'(exp_lat));
        chk({tag, "_mean"}, o_bg, exp_q.pop_front());
        chk({tag, "_flags"}, 256'({o_busy, o_val}), 256'(2'b01));
    endtask

    initial begin
        logic [255:0] prev;
        int           v1[4] = '{10, 20, 30, 41};
        int           v2[4] = '{-1, -2, -2, -2};

        sel          = 0;
        rst          = 1'b1;
        start        = 1'b0;
        period_valid = 1'b0;
        period_data  = '0;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            chk($sformatf("reset_bg_%0d", d), o_bg, 256'(0));
            chk($sformatf("reset_flags_%0d", d), 256'({o_busy, o_upd, o_val}), 256'(0));
        end
        sel = 0;
        rst = 1'b0;
        step();

        // Lane 0 mean of 10,20,30,41.
        beats.delete();
        foreach (v1[k]) beats.push_back(lane_vec(0, v1[k]));
        estimate("l2_lane0", 2, 1'b0, '0, 5);
        chk("l2_lane0_const", 256'(o_bg[15:0]), 256'(16'h0019));
        prev = o_bg;
        step();
        chk("l2_update_pulse", 256'({o_upd, o_busy}), 256'(0));
        chk("l2_hold_after", o_bg, prev);

        // Negative floor on lane 5; every other lane zero.
        beats.delete();
        foreach (v2[k]) beats.push_back(lane_vec(5, v2[k]));
        estimate("l2_lane5", 2, 1'b0, '0, 5);
        chk("l2_lane5_const", o_bg, 256'(16'hFFFE) << 80);

        // period_valid while idle is ignored.
        prev = o_bg;
        repeat (3) begin
            period_valid = 1'b1;
            period_data  = rand_vec();
            step();
        end
        period_valid = 1'b0;
        chk("idle_ignore_flags", 256'({o_busy, o_upd}), 256'(0));
        chk("idle_ignore_bg", o_bg, prev);

        // Gapped valids with stray starts during ACCUM.
        beats.delete();
        repeat (4) beats.push_back(rand_vec());
        gaps        = '{1, 0, 0, 1, 1, 0, 1};
        extra_start = '{0, 1, 0, 0, 1, 0, 0};
        estimate("l2_gaps", 2, 1'b0, '0, 8);

        beats.delete();
        repeat (4) beats.push_back(rand_vec());
        estimate("l2_rand", 2, 1'b0, '0, 5);

        // Reset after two beats, then a clean estimate of 8s.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) begin
            period_valid = 1'b1;
            period_data  = rand_vec();
            step();
        end
        period_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_bg", o_bg, 256'(0));
        chk("rst_mid_flags", 256'({o_busy, o_upd, o_val}), 256'(0));
        step();
        rst = 1'b0;
        step();
        beats.delete();
        repeat (4) beats.push_back({16{8'd8}});
        estimate("l2_after_rst", 2, 1'b0, '0, 5);
        chk("l2_after_rst_const", o_bg, {16{16'h0008}});

        // Back-to-back: second start lands in the noise_update cycle with a junk beat.
        beats.delete();
        repeat (4) beats.push_back(rand_vec());
        estimate("b2b_first", 2, 1'b0, '0, 5);
        beats.delete();
        repeat (4) beats.push_back(rand_vec());
        estimate("b2b_second", 2, 1'b1, {16{8'h7F}}, 5);

        // 256-beat extremes.
        sel = 1;
        #1;
        beats.delete();
        repeat (256) beats.push_back({16{8'h80}});
        estimate("l8_min", 8, 1'b0, '0, 257);
        chk("l8_min_const", o_bg, {16{16'hFF80}});
        beats.delete();
        repeat (256) beats.push_back({16{8'h7F}});
        estimate("l8_max", 8, 1'b0, '0, 257);
        chk("l8_max_const", o_bg, {16{16'h007F}});

        // Single-beat estimate passes the sample straight through.
        sel = 2;
        #1;
        beats.delete();
        beats.push_back(lane_vec(3, -7));
        estimate("l0_neg", 0, 1'b0, '0, 2);
        chk("l0_neg_const", o_bg, 256'(16'hFFF9) << 48);
        beats.delete();
        beats.push_back(rand_vec());
        estimate("l0_rand", 0, 1'b0, '0, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
